// File: rtl/prime_detector_pkg.sv
// Shared types and defaults for the prime detector slice.
// No logic of its own; no latency or backpressure.
package prime_detector_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/prime_detector_if.sv
// Operand/result bundle between a requester (master) and the detector (slave).
// start is honoured only while busy is low; done is a one-cycle result strobe.
interface prime_detector_if
    import prime_detector_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);

    logic [WIDTH-1:0] N;
    logic             start;
    logic             busy;
    logic             done;
    logic             F;

    modport master (output N, output start, input busy, input done, input F);
    modport slave  (input N, input start, output busy, output done, output F);

endinterface

// File: rtl/prime_rem_unit.sv
// Restoring remainder, one quotient bit per cycle: o_rem_valid pulses WIDTH cycles after i_go.
// Operands are captured on i_go, so the caller may change them while the unit runs.
module prime_rem_unit
    import prime_detector_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_go,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_rem_valid
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic             r_valid;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    // The partial remainder stays below the divisor, so the difference fits in WIDTH bits.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_diff  = w_shift[WIDTH-1:0] - r_div;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_quo   <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_go) begin
                r_quo <= i_dividend;
                r_rem <= '0;
                r_div <= i_divisor;
                r_cnt <= CW'(WIDTH);
            end else if (r_cnt != '0) begin
                r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign o_rem       = r_rem;
    assign o_rem_valid = r_valid;

endmodule

// File: rtl/prime_detector.sv
// Primality test: trivial operands finish 1 cycle after acceptance, odd ones by trial division.
// start is ignored while busy (no queuing); a new start is taken the cycle after done.
module prime_detector
    import prime_detector_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    prime_detector_if.slave  bus
);

    state_t           r_state;
    logic [WIDTH-1:0] r_op;
    logic [WIDTH-1:0] r_d;
    logic             r_busy;
    logic             r_done;
    logic             r_f;
    logic             r_go;
    logic             r_wait;

    logic [WIDTH-1:0]   w_rem;
    logic               w_rem_vld;
    logic [2*WIDTH-1:0] w_dsq;
    logic               w_d_over;
    logic               w_fast;
    logic               w_fast_f;

    // Double-width square so the loop bound never wraps.
    assign w_dsq    = {{WIDTH{1'b0}}, r_d} * {{WIDTH{1'b0}}, r_d};
    assign w_d_over = (w_dsq > {{WIDTH{1'b0}}, r_op});

    assign w_fast   = (bus.N <= WIDTH'(3)) || !bus.N[0];
    assign w_fast_f = (bus.N == WIDTH'(2)) || (bus.N == WIDTH'(3));

    prime_rem_unit #(.WIDTH(WIDTH)) u_rem (
        .clk         (clk),
        .rst         (rst),
        .i_dividend  (r_op),
        .i_divisor   (r_d),
        .i_go        (r_go),
        .o_rem       (w_rem),
        .o_rem_valid (w_rem_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_d     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_f     <= 1'b0;
            r_go    <= 1'b0;
            r_wait  <= 1'b0;
        end else begin
            r_go   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_op <= bus.N;
                        if (w_fast) begin
                            r_f     <= w_fast_f;
                            r_done  <= 1'b1;
                            r_state <= ST_FINISH;
                        end else begin
                            r_d     <= WIDTH'(3);
                            r_wait  <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    // r_wait separates "decide next divisor" from "await remainder".
                    if (!r_wait) begin
                        if (w_d_over) begin
                            r_f     <= 1'b1;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_FINISH;
                        end else begin
                            r_go   <= 1'b1;
                            r_wait <= 1'b1;
                        end
                    end else if (w_rem_vld) begin
                        if (w_rem == '0) begin
                            r_f     <= 1'b0;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_FINISH;
                        end else begin
                            r_d    <= r_d + WIDTH'(2);
                            r_wait <= 1'b0;
                        end
                    end
                end
                ST_FINISH: begin
                    r_wait  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.F    = r_f;

endmodule

// File: tb/tb_prime_detector.sv
// Directed bench for prime_detector at WIDTH=4 and WIDTH=8 with a result scoreboard.
module tb_prime_detector;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    prime_detector_if #(.WIDTH(4)) if4 ();
    prime_detector_if #(.WIDTH(8)) if8 ();

    prime_detector #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
    prime_detector #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

    int n_cmp = 0;
    int n_err = 0;
    bit sb[$];

    function automatic bit ref_prime(input int n);
        if (n < 2) return 1'b0;
        for (int k = 2; k < n; k++) begin
            if (n % k == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic get_out(input bit w8, output logic b, output logic d, output logic f);
        b = w8 ? if8.busy : if4.busy;
        d = w8 ? if8.done : if4.done;
        f = w8 ? if8.F    : if4.F;
    endtask

    // One operand from the idle cycle to its done; optionally pokes start with N=4 while busy.
    task automatic run(input bit w8, input int n, input bit fast, input bit inject, input int budget);
        int   cyc;
        logic b, d, f;
        bit   exp_f;
        @(negedge clk);
        get_out(w8, b, d, f);
        chk($sformatf("idle_busy N=%0d", n), {31'd0, b}, 32'd0);
        if (w8) begin
            if8.N = 8'(n);
            if8.start = 1'b1;
        end else begin
            if4.N = 4'(n);
            if4.start = 1'b1;
        end
        sb.push_back(ref_prime(n));
        @(negedge clk);
        if4.start = 1'b0;
        if8.start = 1'b0;
        cyc = 1;
        get_out(w8, b, d, f);
        while (!d && cyc < budget) begin
            chk($sformatf("busy_high N=%0d cyc=%0d", n, cyc), {31'd0, b}, 32'd1);
            if (inject) begin
                if4.N = 4'd4;
                if4.start = (cyc <= 3);
            end
            @(negedge clk);
            cyc++;
            get_out(w8, b, d, f);
        end
        if4.start = 1'b0;
        chk($sformatf("done_seen N=%0d", n), {31'd0, d}, 32'd1);
        if (d) begin
            chk($sformatf("busy_at_done N=%0d", n), {31'd0, b}, 32'd0);
            if (sb.size() == 0) begin
                chk($sformatf("sb_nonempty N=%0d", n), 32'd0, 32'd1);
            end else begin
                exp_f = sb.pop_front();
                chk($sformatf("F N=%0d", n), {31'd0, f}, {31'd0, exp_f});
            end
            if (fast) chk($sformatf("fast_latency N=%0d", n), 32'(cyc), 32'd1);
        end else begin
            void'(sb.pop_front());
        end
    endtask

    initial begin
        logic b, d, f;
        rst = 1'b1;
        if4.N = '0;
        if4.start = 1'b0;
        if8.N = '0;
        if8.start = 1'b0;
        repeat (3) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            get_out(w[0], b, d, f);
            chk($sformatf("rst_busy w%0d", w), {31'd0, b}, 32'd0);
            chk($sformatf("rst_done w%0d", w), {31'd0, d}, 32'd0);
            chk($sformatf("rst_F w%0d", w), {31'd0, f}, 32'd0);
        end
        rst = 1'b0;

        run(1'b0, 2, 1'b1, 1'b0, 100);
        run(1'b0, 8, 1'b1, 1'b0, 100);
        run(1'b0, 9, 1'b0, 1'b0, 100);
        run(1'b0, 13, 1'b0, 1'b0, 100);

        for (int n = 0; n < 16; n++) begin
            run(1'b0, n, (n < 4) || (n % 2 == 0), 1'b0, 100);
        end

        // start with N=4 during busy must be dropped: one done with F=1, then silence.
        run(1'b0, 13, 1'b0, 1'b1, 100);
        repeat (4) begin
            @(negedge clk);
            chk("no_extra_done", {31'd0, if4.done}, 32'd0);
        end

        // Abort N=15 while the remainder unit is running.
        @(negedge clk);
        if4.N = 4'd15;
        if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_before_abort", {31'd0, if4.busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, if4.busy}, 32'd0);
        chk("abort_done", {31'd0, if4.done}, 32'd0);
        chk("abort_F", {31'd0, if4.F}, 32'd0);
        repeat (12) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, if4.done}, 32'd0);
        end
        run(1'b0, 11, 1'b0, 1'b0, 100);

        run(1'b1, 251, 1'b0, 1'b0, 500);
        run(1'b1, 221, 1'b0, 1'b0, 500);
        run(1'b1, 255, 1'b0, 1'b0, 500);

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prime_detector.md
PRIME_DETECTOR -- requirements
Module: prime_detector

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; legal range 2..16.
REQ-002 Port: clk  input  1  single system clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port: N  input  WIDTH  unsigned operand under test; sampled only when start is accepted.
REQ-005 Port: start  input  1  request to test N; accepted only when busy=0.
REQ-006 Port: busy  output  1  high from the cycle after acceptance until done.
REQ-007 Port: done  output  1  one-cycle pulse marking F valid for the accepted operand.
REQ-008 Port: F  output  1  1 = operand is prime, 0 = not prime; held until the next done.

Function
REQ-009 Prime definition: integer >= 2 with no divisor in 2..N-1; 0 and 1 are not prime.
REQ-010 Acceptance: start=1 with busy=0 latches N into an internal operand register; start while busy=1 is ignored, with no queuing.
REQ-011 FSM states: IDLE, CHECK, FINISH; reset enters IDLE.
REQ-012 Fast path in IDLE on acceptance: operand 0 or 1 gives F=0; operand 2 or 3 gives F=1; even operand >= 4 gives F=0; FSM goes directly to FINISH; done is high exactly 1 cycle after the acceptance edge.
REQ-013 Slow path: odd operand >= 5 enters CHECK with trial divisor d=3.
REQ-014 CHECK loop: if d*d > operand, the result is F=1 and the FSM goes to FINISH; else the remainder operand mod d is computed by the sub-module.
REQ-015 CHECK decision: remainder 0 gives F=0 and the FSM goes to FINISH; otherwise d advances by 2 and the loop repeats.
REQ-016 Arithmetic widths: d is WIDTH bits; the d*d comparison uses 2*WIDTH bits, so there is no overflow or wrap-around.
REQ-017 FINISH: done=1 and busy=0 for one cycle, F updated on that same edge, then return to IDLE.
REQ-018 Back-to-back operation: start is accepted in the cycle after done.
REQ-019 F and done change only on rising clk; there are no combinational input-to-output paths.
REQ-020 WIDTH=4 truth table: F=1 exactly for N in {2,3,5,7,11,13}; F=0 for N in {0,1,4,6,8,9,10,12,14,15}.

Reset
REQ-021 rst=1 forces FSM=IDLE, busy=0, done=0, F=0, and clears the operand register, the divisor register and the sub-module state.
REQ-022 Reset mid-operation aborts the test; no done is produced for the aborted operand.
REQ-023 rst has priority over start in the same cycle.

Structure
REQ-024 A shared package holds the FSM state enumeration and the WIDTH default constant.
REQ-025 One sub-module, prime_rem_unit: sequential restoring remainder with inputs dividend, divisor and go, and outputs rem and rem_valid; latency WIDTH cycles per divisor.
REQ-026 Top level contains only the FSM, fast-path decode, divisor/operand registers and the output registers.

Verification
REQ-027 Sweep N=0..15 with WIDTH=4, one start per done -> F matches REQ-020 for every value.
REQ-028 Fast path: start with N=2, then N=8 -> done exactly 1 cycle after each acceptance, with F=1 and F=0 respectively.
REQ-029 Slow path: N=9 -> F=0; N=13 -> F=1; busy stays high throughout each test until done.
REQ-030 Start while busy: N=13 accepted, then N=4 presented with start=1 during busy -> single done with F=1; N=4 is dropped.
REQ-031 Reset: assert rst during CHECK for N=15 -> next cycle busy=0, done=0, F=0; subsequent N=11 -> F=1.
REQ-032 WIDTH=8: N=251 -> F=1; N=221 (13*17) -> F=0; N=255 -> F=0.
